// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the fetch-stage program counter unit.
//   pc_state_e      : BOOT / RUN / FAULT states of the PC controller
//   PC_RESET_VECTOR : default address loaded while reset is asserted
//   align_mask()    : mask of the low address bits that must be zero for a
//                     legal instruction address at a given IALIGN (2 or 4)
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT  = 2'd0,
    PC_RUN   = 2'd1,
    PC_FAULT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

  // IALIGN is a power of two (2 or 4), so IALIGN-1 selects exactly the
  // address bits below the instruction granule. Returned at 64 bits so any
  // XLEN up to RV64 can take a slice of it.
  function automatic logic [63:0] align_mask(input int ialign);
    return 64'(ialign - 1);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// ---------------------------------------------------------------------------
// pc_next_sel
// Combinational next-PC / next-state selection for pc_unit.
// Ports:
//   i_state        current controller state
//   i_pc           current fetch address
//   i_stall        hold request (no sequential advance)
//   i_fetch_ready  instruction memory accepts the current address
//   i_br_taken     branch/jump redirect request, target in i_br_target
//   i_trap         trap redirect request, handler in i_trap_vec
//   o_next_pc      address to load on the next edge
//   o_next_state   state to enter on the next edge
//   o_fault        misaligned branch seen; capture i_br_target as bad address
// ---------------------------------------------------------------------------
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = 4
) (
  input  pc_state_e         i_state,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_stall,
  input  logic              i_fetch_ready,
  input  logic              i_br_taken,
  input  logic [XLEN-1:0]   i_br_target,
  input  logic              i_trap,
  input  logic [XLEN-1:0]   i_trap_vec,
  output logic [XLEN-1:0]   o_next_pc,
  output pc_state_e         o_next_state,
  output logic              o_fault
);

  localparam logic [63:0]     MASK64 = align_mask(IALIGN);
  localparam logic [XLEN-1:0] MASK   = MASK64[XLEN-1:0];
  localparam logic [XLEN-1:0] STEP   = XLEN'(IALIGN);

  logic [XLEN-1:0] w_trap_pc;
  logic            w_br_misaligned;

  // Trap handlers are always entered on a legal boundary, so the low bits of
  // the vector are simply dropped rather than treated as a fault.
  assign w_trap_pc       = i_trap_vec & ~MASK;
  assign w_br_misaligned = |(i_br_target & MASK);

  // Redirects outrank the handshake: trap first, then branch, and only then
  // do stall / fetch_ready decide whether the sequential advance happens.
  always_comb begin
    o_next_pc    = i_pc;
    o_next_state = i_state;
    o_fault      = 1'b0;
    unique case (i_state)
      PC_BOOT: begin
        o_next_state = PC_RUN;
        if (i_trap) o_next_pc = w_trap_pc;
      end
      PC_RUN: begin
        if (i_trap) begin
          o_next_pc = w_trap_pc;
        end else if (i_br_taken) begin
          if (w_br_misaligned) begin
            o_next_state = PC_FAULT;
            o_fault      = 1'b1;
          end else begin
            o_next_pc = i_br_target;
          end
        end else if (!i_stall && i_fetch_ready) begin
          o_next_pc = i_pc + STEP;
        end
      end
      PC_FAULT: begin
        if (i_trap) begin
          o_next_pc    = w_trap_pc;
          o_next_state = PC_RUN;
        end
      end
      default: begin
        o_next_state = PC_BOOT;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter for the RISC-V fetch stage.
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   stall          hold the PC
//   br_taken       branch/jump redirect to br_target
//   trap           trap redirect to trap_vec (aligned down)
//   fetch_ready    instruction memory accepts pc_out this cycle
//   fetch_valid    pc_out is a valid fetch request (RUN state)
//   pc_out         current fetch address (registered)
//   pc_plus4       pc_out + 4 for link values (combinational)
//   misalign       high while parked on a misaligned branch target
//   bad_addr       offending branch target captured on fault entry
// IALIGN must be 2 or 4.
// ---------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
  parameter int              IALIGN       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign,
  output logic [XLEN-1:0] bad_addr
);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fetch_valid;
  logic            r_misalign;
  logic [XLEN-1:0] r_bad_addr;

  pc_state_e       w_next_state;
  logic [XLEN-1:0] w_next_pc;
  logic            w_fault;

  pc_next_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_next_sel (
    .i_state       (r_state),
    .i_pc          (r_pc),
    .i_stall       (stall),
    .i_fetch_ready (fetch_ready),
    .i_br_taken    (br_taken),
    .i_br_target   (br_target),
    .i_trap        (trap),
    .i_trap_vec    (trap_vec),
    .o_next_pc     (w_next_pc),
    .o_next_state  (w_next_state),
    .o_fault       (w_fault)
  );

  // Status outputs are registered from the next state so they line up with
  // the state they describe; bad_addr only moves on a fresh fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= PC_BOOT;
      r_pc          <= RESET_VECTOR;
      r_fetch_valid <= 1'b0;
      r_misalign    <= 1'b0;
      r_bad_addr    <= '0;
    end else begin
      r_state       <= w_next_state;
      r_pc          <= w_next_pc;
      r_fetch_valid <= (w_next_state == PC_RUN);
      r_misalign    <= (w_next_state == PC_FAULT);
      if (w_fault) r_bad_addr <= br_target;
    end
  end

  // Link value is always +4 regardless of IALIGN; wraps modulo 2^XLEN.
  assign pc_plus4    = r_pc + XLEN'(4);
  assign pc_out      = r_pc;
  assign fetch_valid = r_fetch_valid;
  assign misalign    = r_misalign;
  assign bad_addr    = r_bad_addr;

endmodule
